ge_compare_arbiter: RTL and testbench
=====================================

# ge_compare_arbiter

Shares one signed 32-bit greater-or-equal comparator (`greaterOrEqual`) among N_REQ requesters using round-robin arbitration. It sits between the ALU's compare-issuing clients and the comparator datapath. It accepts one operand pair at a time with a valid/ready handshake and returns the 1-bit result tagged with the requester ID on a single response port with backpressure.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; operands are signed two's complement
- ID_W, $clog2(N_REQ), response ID width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high
- req_a  in  N_REQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand b; same packing as req_a
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_ge  out  1  1 iff signed a >= signed b
- busy  out  1  high in any state other than IDLE

## Operation
- FSM has three states: IDLE, CMP, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - req_ready[winner] is driven combinationally in IDLE only.
  - A handshake (valid & ready) latches a_q, b_q and id_q, then moves to CMP.
- CMP: a_q and b_q drive `greaterOrEqual`; its eq output is registered into ge_q; move to RESP.
- RESP:
  - rsp_valid = 1; rsp_id = id_q; rsp_ge = ge_q. All three hold stable until rsp_ready.
  - On rsp_valid & rsp_ready, rr_ptr is set to (id_q + 1) mod N_REQ and the FSM returns to IDLE.
- Comparison is full-width signed. There is no overflow path: subtraction-based implementations must use WIDTH+1 bits.
- A requester may drop req_valid before it is granted. Nothing is latched and no response is generated for it.
- req_a and req_b are sampled only on the handshake cycle. Later changes do not affect the result in flight.
- Fairness: after requester i is served, every other requester that is continuously asserting valid is granted before i is granted again.
- req_valid is ignored in CMP and RESP; req_ready is all-zero in those states.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, req_ready = 0 (unless req_valid is high in the same cycle after reset releases), rsp_valid = 0, rsp_id = 0, rsp_ge = 0, busy = 0.
- Handshake at clock edge T puts the FSM in CMP during T+1 and gives rsp_valid = 1 during T+2. Minimum latency is 2 cycles.
- If rsp_ready is high in the first RESP cycle, the FSM is in IDLE during T+3. The next handshake can complete in that cycle, giving a peak throughput of one compare per 3 cycles.
- With rsp_ready low, RESP holds indefinitely; outputs stay unchanged and no new request is accepted.
- rst asserted in any state forces the reset values on the next edge. An in-flight compare is discarded with no response, and rr_ptr returns to 0.
- All req_valid asserted simultaneously from reset gives a grant order of 0, 1, 2, 3, 0, …

## Structure
- Shared package `ge_arb_pkg` holds:
  - state enum {IDLE, CMP, RESP}
  - default N_REQ and WIDTH constants
  - an `rr_next(ptr, req)` function for the round-robin priority search
- Sub-module: the existing `greaterOrEqual` (ports a, b, eq), instantiated once. The block adds no second comparator.
- The round-robin search is combinational and lives in the package function; no separate arbiter module.

## Test plan
- Single request: requester 2 sends a = 5, b = -3. Required: req_ready[2] for one cycle, then rsp_valid two cycles later with rsp_id = 2, rsp_ge = 1.
- Signed boundaries, one compare each:
  - a = -2147483648, b = 2147483647 -> ge = 0
  - a = 2147483647, b = -2147483648 -> ge = 1
  - a = b = -1 -> ge = 1
  - a = -2, b = -1 -> ge = 0
- All four requesters held valid (pairs (1,2), (2,1), (0,0), (-1,2)), rsp_ready = 1. Required: responses in ID order 0, 1, 2, 3 with ge = 0, 1, 1, 0, then the grant wraps back to 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP. Required: rsp_valid, rsp_id and rsp_ge remain constant; req_ready stays 0; only one response is delivered when rsp_ready rises.
- Operand change after accept: requester 1 accepts a = 1, b = 2, then changes to a = 9, b = 0. Required: rsp_ge = 0.
- Reset mid-operation: assert rst in CMP. Required: the next cycle shows rsp_valid = 0, busy = 0, and no response for the dropped request. With requesters 0 and 3 then valid, requester 0 is granted first (rr_ptr = 0).

Source files
------------

// File: rtl/ge_arb_pkg.sv
// Shared types and helpers for the round-robin signed compare arbiter.
// Holds the FSM state enum, default sizes and the rr_next priority search.
package ge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int MAX_REQ   = 8;

  // First set bit of req at or above ptr, wrapping modulo n.
  // Returns ptr unchanged when nothing is requested.
  function automatic logic [2:0] rr_next(
    input logic [2:0]         ptr,
    input logic [MAX_REQ-1:0] req,
    input int                 n
  );
    logic hit;
    int   idx;
    hit     = 1'b0;
    rr_next = ptr;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !hit && req[idx[2:0]]) begin
        hit     = 1'b1;
        rr_next = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/ge_compare_arbiter_if.sv
// Request/response bundle between compare clients and the arbiter.
// master: clients (valid, operands, rsp_ready); slave: arbiter.
interface ge_compare_arbiter_if
  import ge_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_ge;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_ge
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_ge
  );

endinterface

// File: rtl/greaterOrEqual.sv
// Full-width signed a >= b comparator.
// Ports: a, b operands (two's complement); eq = 1 iff a >= b.
module greaterOrEqual #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = $signed(a) >= $signed(b);

endmodule

// File: rtl/ge_compare_arbiter.sv
// Round-robin sharing of one signed >= comparator among N_REQ clients.
// Ports: clk, rst (sync, high), bus (slave request/response), busy.
module ge_compare_arbiter
  import ge_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  ge_compare_arbiter_if.slave  bus,
  output logic                 busy
);

  state_t             state;
  state_t             state_n;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic               ge_q;
  logic               ge_w;
  logic               hs;
  logic [MAX_REQ-1:0] vld_ext;

  assign vld_ext = MAX_REQ'(bus.req_valid);
  assign win     = ID_W'(rr_next(3'(rr_ptr), vld_ext, N_REQ));

  greaterOrEqual #(
    .WIDTH (WIDTH)
  ) u_ge (
    .a  (a_q),
    .b  (b_q),
    .eq (ge_w)
  );

  // Constant-index mux keeps the operand select free of wide indices.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    hs            = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          bus.req_ready[win] = 1'b1;
          hs                 = 1'b1;
          state_n            = CMP;
        end
      end
      CMP:  state_n = RESP;
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_ge    = ge_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      ge_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      state <= state_n;
      if (hs) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= win;
      end
      if (state == CMP) ge_q <= ge_w;
      if (bus.rsp_valid && bus.rsp_ready) begin
        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0
                : id_q + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ge_compare_arbiter.sv
// Scoreboard bench for ge_compare_arbiter with a round-robin model.
// Stimulus pushes expected {id, ge}; a monitor pops on each response.
module tb_ge_compare_arbiter;
  import ge_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  ge_compare_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  ge_compare_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    int   id;
    logic ge;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;
  int cyc      = 0;
  int mptr     = 0;
  int rmode    = 1;

  logic [N-1:0] vv;
  logic [W-1:0] va[N];
  logic [W-1:0] vb[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic ref_ge(logic [W-1:0] a, logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa >= sb;
  endfunction

  function automatic int ref_win(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return W'($urandom_range(0, 6)) - 32'd3;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic apply();
    bus.req_valid = vv;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = va[i];
      bus.req_b[i*W +: W] = vb[i];
    end
  endtask

  task automatic grant(output int w);
    int t;
    t = 0;
    w = -1;
    while (t < 60) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
      t++;
    end
    if (t >= 60) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    w = ref_win(vv, mptr);
    chk("grant_onehot", bus.req_ready, (w < 0) ? 0 : (1 << w));
    if (w >= 0) begin
      q.push_back('{w, ref_ge(va[w], vb[w]), cyc});
      pushes++;
      mptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic one_req(int r, logic [W-1:0] a, logic [W-1:0] b);
    int w;
    wait_idle();
    vv    = N'(1 << r);
    va[r] = a;
    vb[r] = b;
    apply();
    grant(w);
    vv = '0;
    apply();
  endtask

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) bus.rsp_ready = 1'($urandom_range(0, 1));
      else            bus.rsp_ready = (rmode == 1);
    end
  end

  initial begin
    logic pv;
    logic pacc;
    exp_t e;
    pv   = 1'b0;
    pacc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        continue;
      end
      if (busy) chk("ready_when_busy", bus.req_ready, 0);
      if (pv && !pacc) chk("rsp_hold", bus.rsp_valid, 1);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = q[0];
          if (!pv || pacc) chk("latency", cyc - e.cyc, 2);
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_ge", bus.rsp_ge, e.ge);
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
      pv   = bus.rsp_valid;
      pacc = bus.rsp_valid && bus.rsp_ready;
    end
  end

  initial begin
    int w;
    int t;
    vv = '0;
    for (int i = 0; i < N; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    apply();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_rsp_ge", bus.rsp_ge, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;

    one_req(2, 32'd5, 32'hFFFF_FFFD);
    @(negedge clk);
    chk("ready_one_cycle", bus.req_ready, 0);

    one_req(0, 32'h8000_0000, 32'h7FFF_FFFF);
    one_req(1, 32'h7FFF_FFFF, 32'h8000_0000);
    one_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    one_req(3, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

    wait_idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mptr = 0;
    va[0] = 32'd1;          vb[0] = 32'd2;
    va[1] = 32'd2;          vb[1] = 32'd1;
    va[2] = 32'd0;          vb[2] = 32'd0;
    va[3] = 32'hFFFF_FFFF;  vb[3] = 32'd2;
    vv = 4'hF;
    apply();
    repeat (5) grant(w);
    vv = '0;
    apply();

    wait_idle();
    rmode = 2;
    vv    = 4'b0010;
    va[1] = rnd_op();
    vb[1] = rnd_op();
    apply();
    grant(w);
    vv = 4'b0101;
    apply();
    t = 0;
    while (!bus.rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    repeat (5) @(posedge clk);
    #1;
    vv = '0;
    apply();
    rmode = 1;

    wait_idle();
    vv    = 4'b0010;
    va[1] = 32'd1;
    vb[1] = 32'd2;
    apply();
    grant(w);
    va[1] = 32'd9;
    vb[1] = 32'd0;
    vv    = '0;
    apply();

    wait_idle();
    vv    = 4'b0100;
    va[2] = rnd_op();
    vb[2] = rnd_op();
    apply();
    grant(w);
    rst = 1'b1;
    vv  = '0;
    apply();
    if (q.size() != 0) begin
      void'(q.pop_back());
      pushes--;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mptr = 0;
    @(negedge clk);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1;
    vv = 4'b1001;
    apply();
    grant(w);
    vv = 4'b1000;
    apply();
    grant(w);
    vv = '0;
    apply();

    wait_idle();
    rmode = 0;
    repeat (40) begin
      vv = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        va[i] = rnd_op();
        vb[i] = rnd_op();
      end
      apply();
      grant(w);
    end
    vv = '0;
    apply();
    rmode = 1;
    wait_idle();
    chk("queue_empty", q.size(), 0);
    chk("rsp_count", pops, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
